// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: decode stage with the ID/EX register, hazard stalls, jump/branch redirect and HALT control.
// The ins/fetch_addr relationship assumes a one-cycle synchronous fetch memory.
module decode_hazard_ctrl #(
    parameter int AW    = 16,
    parameter int IW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IW-1:0]    ins,
    input  logic [AW-1:0]    fetch_addr,
    input  logic             zero_flag,
    input  logic             resume,
    output logic             stall,
    output logic             stall_pm,
    output logic             pc_mux_sel,
    output logic [AW-1:0]    jmp_loc,
    output logic             dec_valid,
    output logic [5:0]       dec_opcode,
    output logic [4:0]       dec_rd,
    output logic [4:0]       dec_rs1,
    output logic [15:0]      dec_imm,
    output logic [AW-1:0]    dec_pc,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_ALU   = 6'h01;
    localparam logic [5:0] OP_LOAD  = 6'h02;
    localparam logic [5:0] OP_STORE = 6'h03;
    localparam logic [5:0] OP_JMP   = 6'h04;
    localparam logic [5:0] OP_BZ    = 6'h05;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic {RUN, HALTED} state_t;

    state_t        state, state_d;
    logic [AW-1:0] ins_pc;
    logic [5:0]    op;
    logic [4:0]    rs1;
    logic          is_legal, reads_rs1, load_use, flag_haz, redirect, run_stall, load_idex;

    assign op        = ins[31:26];
    assign rs1       = ins[20:16];
    assign is_legal  = op inside {OP_NOP, OP_ALU, OP_LOAD, OP_STORE, OP_JMP, OP_BZ, OP_HALT};
    assign reads_rs1 = op inside {OP_ALU, OP_LOAD, OP_STORE};
    assign load_use  = dec_valid && dec_opcode == OP_LOAD && dec_rd != 5'd0 && reads_rs1 && rs1 == dec_rd;
    assign flag_haz  = op == OP_BZ && dec_valid && dec_opcode == OP_ALU;
    assign redirect  = op == OP_JMP || (op == OP_BZ && zero_flag);
    assign run_stall = op == OP_HALT || load_use || flag_haz;
    assign stall_pm  = 1'b0;
    assign halted    = state == HALTED;

    always_comb begin
        state_d    = state;
        stall      = 1'b0;
        pc_mux_sel = 1'b0;
        jmp_loc    = '0;
        load_idex  = 1'b0;
        if (state == RUN) begin
            stall      = run_stall;
            pc_mux_sel = !run_stall && redirect;
            jmp_loc    = (!run_stall && redirect) ? AW'(ins[15:0]) : '0;
            load_idex  = !run_stall;
            state_d    = op == OP_HALT ? HALTED : RUN;
        end else begin
            stall      = !resume;
            pc_mux_sel = resume;
            jmp_loc    = resume ? ins_pc + AW'(1) : '0;
            state_d    = resume ? RUN : HALTED;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            ins_pc <= '0;
        end else begin
            state <= state_d;
            ins_pc <= fetch_addr;
        end
    end

    // A stalled or halted cycle writes an all-zero bubble into ID/EX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_valid  <= 1'b0;
            dec_opcode <= '0;
            dec_rd     <= '0;
            dec_rs1    <= '0;
            dec_imm    <= '0;
            dec_pc     <= '0;
        end else begin
            dec_valid  <= load_idex && is_legal && op != OP_NOP;
            dec_opcode <= load_idex ? op : '0;
            dec_rd     <= load_idex ? ins[25:21] : '0;
            dec_rs1    <= load_idex ? rs1 : '0;
            dec_imm    <= load_idex ? ins[15:0] : '0;
            dec_pc     <= load_idex ? ins_pc : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_op <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            illegal_op <= illegal_op || (state == RUN && !is_legal);
            stall_cnt  <= (stall && !(&stall_cnt)) ? stall_cnt + CNT_W'(1) : stall_cnt;
        end
    end
endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
- Instruction decode stage directly downstream of the program-memory/fetch stage.
- Consumes the fetched 32-bit instruction and fetch address, and registers decoded fields into the ID/EX pipeline register.
- Drives the fetch stage's control inputs (stall, stall_pm, pc_mux_sel, jmp_loc) for load-use stalls, jumps, conditional branches and HALT.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- AW, 16, instruction address width
- IW, 32, instruction width
- CNT_W, 16, stall counter width

Ports:
- clk  input  1  single clock; all flops rise on posedge clk
- reset  input  1  asynchronous, active-high reset
- ins  input  IW  instruction from fetch, valid every cycle
- fetch_addr  input  AW  address fetch is issuing this cycle (its current_address)
- zero_flag  input  1  registered zero flag from execute
- resume  input  1  single-cycle pulse that leaves HALTED
- stall  output  1  to fetch: re-issue previous address
- stall_pm  output  1  to fetch: hold previous instruction; constant 0, reserved
- pc_mux_sel  output  1  to fetch: select jmp_loc
- jmp_loc  output  AW  redirect target
- dec_valid  output  1  ID/EX register holds a real instruction
- dec_opcode  output  6  registered ins[31:26]
- dec_rd  output  5  registered ins[25:21]
- dec_rs1  output  5  registered ins[20:16]
- dec_imm  output  16  registered ins[15:0]
- dec_pc  output  AW  address of the decoded instruction
- halted  output  1  FSM in HALTED
- illegal_op  output  1  sticky: unknown opcode seen
- stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Encoding: opcode ins[31:26].
  - 0x00 NOP
  - 0x01 ALU (writes rd and zero flag, reads rs1)
  - 0x02 LOAD (writes rd, reads rs1)
  - 0x03 STORE (reads rs1)
  - 0x04 JMP (target imm16)
  - 0x05 BZ (target imm16 if zero_flag)
  - 0x3F HALT
  - Any other opcode decodes as NOP and sets illegal_op.
- Fetch memory is synchronous: the address issued in cycle t yields ins in t+1.
  - ins_pc register = fetch_addr delayed one cycle, so it is the address of the current ins.
- Reset (async): all registered outputs 0, state RUN, dec_valid=0, stall_cnt=0, illegal_op=0, ins_pc=0.
  - Combinational outputs evaluate from reset register values.
- FSM states: RUN, HALTED.
- RUN, evaluated combinationally on ins each cycle, in priority order:
  1. HALT: stall=1; next state HALTED; ID/EX loads a bubble (dec_valid=0).
  2. Load-use: dec_valid=1, dec_opcode=LOAD, dec_rd != 0, ins is ALU/LOAD/STORE, and ins rs1 == dec_rd.
     - stall=1 for one cycle; ID/EX loads a bubble.
     - The same ins is re-presented next cycle, and the bubble clears the hazard.
  3. Flag hazard: ins is BZ and dec_valid=1 with dec_opcode=ALU.
     - stall=1 for one cycle; ID/EX loads a bubble.
     - BZ is evaluated next cycle with the updated zero_flag.
  4. JMP: pc_mux_sel=1, jmp_loc=imm16 in the same cycle. No bubble; no delay slot. JMP itself is loaded into ID/EX valid.
  5. BZ with zero_flag=1: redirect as JMP. BZ with zero_flag=0: fall through.
  6. Otherwise: ID/EX loads ins fields and dec_pc=ins_pc; dec_valid=1, except 0 for NOP and illegal opcodes.
- HALTED:
  - stall=1 every cycle; ID/EX holds a bubble.
  - resume=1: pc_mux_sel=1, jmp_loc=ins_pc+1 (mod 2^AW, 0xFFFF wraps to 0), stall=0; next state RUN.
  - resume in RUN is ignored.
- jmp_loc is 0 whenever pc_mux_sel=0.
- stall and pc_mux_sel are never both 1.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.
- illegal_op clears only on reset.
- Reset asserted mid-stall or while HALTED returns to RUN with all outputs cleared immediately.

Test Plan:
- Reset asserted mid-stream -> all dec_* outputs, stall, pc_mux_sel, stall_cnt read 0 asynchronously, before the next clk edge.
- LOAD rd=3 at addr 0x10, then ALU rs1=3 -> one cycle stall=1 with dec_valid=0; ALU is decoded next cycle with dec_pc=0x11; stall_cnt=1.
- LOAD rd=0, then ALU rs1=0 -> no stall.
- JMP imm=0x0040 at 0x20 -> same cycle pc_mux_sel=1, jmp_loc=0x0040; next ins decoded has dec_pc=0x0040; no bubble.
- ALU then BZ imm=0x0080 -> one stall cycle, then BZ is evaluated:
  - zero_flag=1 -> redirect to 0x0080.
  - zero_flag=0 -> dec_pc increments to the next address.
- HALT at 0x0030 -> halted=1, stall=1 for 5 cycles, stall_cnt=5; resume pulse -> pc_mux_sel=1, jmp_loc=0x0031, halted=0.
- Opcode 0x2A -> illegal_op=1 and dec_valid=0; illegal_op stays 1 through later instructions until reset.
- Force stall_cnt near all-ones with a long HALT -> stall_cnt holds at 0xFFFF.
